stall_ctrl: RTL

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hazard / stall / flush controller.
//
// Decides per cycle which pipeline stages hold and whether wrong-path
// instructions in IF/ID and ID/EX are discarded. Handles load-use hazards,
// fetch waits, multi-cycle MEM transactions and branch mispredictions.
// A misprediction that arrives during a memory stall is parked and replayed
// as a dedicated flush cycle once the memory stall ends.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rdy                global ready; 0 freezes state, pending flag, counters
//   if_stall_req       IF waiting on an instruction fetch
//   id_rs1/id_rs2      ID source registers, with *_use read qualifiers
//   ex_isload/ex_loadrd load in EX and its destination register
//   mem_req/mem_done   MEM multi-cycle transaction start / completion
//   prediction_res     0 = branch mispredicted (resolved in EX)
//   stall[5:0]         per-stage hold (0 PC .. 5 WB), combinational
//   flush              discard IF/ID and ID/EX, combinational
//   busy               controller is not in RUN (registered)
//
// Optional feature: define STALL_PERF_EN to add saturating performance
// counters perf_mem_cyc, perf_lu_cyc, perf_if_cyc (32 b) and perf_flush (16 b).
module stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_stall_req,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_use,
    input  logic        id_rs2_use,
    input  logic        ex_isload,
    input  logic [4:0]  ex_loadrd,
    input  logic        mem_req,
    input  logic        mem_done,
    input  logic        prediction_res,
    output logic [5:0]  stall,
    output logic        flush,
`ifdef STALL_PERF_EN
    output logic [31:0] perf_mem_cyc,
    output logic [31:0] perf_lu_cyc,
    output logic [31:0] perf_if_cyc,
    output logic [15:0] perf_flush,
`endif
    output logic        busy
);

    localparam int unsigned STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_LU   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_MEM_WAIT   = 2'd1,
        S_FLUSH_PEND = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   pending, pending_nxt;
    logic   mispredict;
    logic   hazard;
    logic   mem_active;
    logic   pend_any;

    // Hazard and memory-stall decode; x0 never hazards.
    always_comb begin
        mispredict = ~prediction_res;
        hazard     = ex_isload && (ex_loadrd != 5'd0) &&
                     ((id_rs1_use && (id_rs1 == ex_loadrd)) ||
                      (id_rs2_use && (id_rs2 == ex_loadrd)));
        mem_active = (state == S_MEM_WAIT) || ((state == S_RUN) && mem_req);
        pend_any   = pending || mispredict;
    end

    // Stall/flush priority; FLUSH_PEND owns its cycle and ignores new requests.
    always_comb begin
        stall = STALL_NONE;
        flush = 1'b0;
        if (!rst) begin
            if (state == S_FLUSH_PEND) begin
                flush = 1'b1;
            end else if (mem_active) begin
                stall = STALL_MEM;
            end else if (mispredict) begin
                flush = 1'b1;
            end else if (hazard) begin
                stall = STALL_LU;
            end else if (if_stall_req) begin
                stall = STALL_IF;
            end
        end
    end

    // Next state; a misprediction seen during a memory stall is replayed afterwards.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            S_RUN: begin
                if (mem_req) begin
                    if (!mem_done) begin
                        state_nxt   = S_MEM_WAIT;
                        pending_nxt = pend_any;
                    end else if (pend_any) begin
                        state_nxt   = S_FLUSH_PEND;
                        pending_nxt = 1'b0;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (mem_done) begin
                    state_nxt   = pend_any ? S_FLUSH_PEND : S_RUN;
                    pending_nxt = 1'b0;
                end else begin
                    pending_nxt = pend_any;
                end
            end
            S_FLUSH_PEND: begin
                state_nxt   = S_RUN;
                pending_nxt = 1'b0;
            end
            default: begin
                state_nxt   = S_RUN;
                pending_nxt = 1'b0;
            end
        endcase
    end

    // State register; rdy=0 freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RUN;
            pending <= 1'b0;
            busy    <= 1'b0;
        end else if (rdy) begin
            state   <= state_nxt;
            pending <= pending_nxt;
            busy    <= (state_nxt != S_RUN);
        end
    end

`ifdef STALL_PERF_EN
    // Each stall code is unique to its cause, so the code itself identifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_mem_cyc <= '0;
            perf_lu_cyc  <= '0;
            perf_if_cyc  <= '0;
            perf_flush   <= '0;
        end else if (rdy) begin
            if ((stall == STALL_MEM) && (perf_mem_cyc != '1))
                perf_mem_cyc <= perf_mem_cyc + 32'(1);
            if ((stall == STALL_LU) && (perf_lu_cyc != '1))
                perf_lu_cyc <= perf_lu_cyc + 32'(1);
            if ((stall == STALL_IF) && (perf_if_cyc != '1))
                perf_if_cyc <= perf_if_cyc + 32'(1);
            if (flush && (perf_flush != '1))
                perf_flush <= perf_flush + 16'(1);
        end
    end
`endif

endmodule
